apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter_if.sv | 43 ++++
 rtl/apb_req_arbiter.sv | 96 +++++++++
 tb/tb_apb_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Bundle between two APB requesters, the arbiter, and the downstream APB master.
// master = arbiter side, slave = requesters plus the bus they observe.
interface apb_req_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STRB_WIDTH    = 4
);
    logic [1:0]                    req;
    logic [1:0][ADDRESS_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0]    req_wdata;
    logic [1:0]                    req_write;
    logic [1:0][STRB_WIDTH-1:0]    req_strb;
    logic [1:0][2:0]               req_prot;
    logic [1:0]                    gnt;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic [ADDRESS_WIDTH-1:0]      IN_ADDR;
    logic [DATA_WIDTH-1:0]         IN_DATA;
    logic                          IN_WRITE;
    logic [STRB_WIDTH-1:0]         IN_STRB;
    logic [2:0]                    IN_PROT;
    logic                          Transfer;
    logic                          PENABLE;
    logic                          PREADY;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PSLVERR;
    logic                          busy;
    logic                          owner;

    modport master (
        input  req, req_addr, req_wdata, req_write, req_strb, req_prot,
        input  PENABLE, PREADY, PRDATA, PSLVERR,
        output gnt, rsp_rdata, rsp_err, busy, owner,
        output IN_ADDR, IN_DATA, IN_WRITE, IN_STRB, IN_PROT, Transfer
    );

    modport slave (
        output req, req_addr, req_wdata, req_write, req_strb, req_prot,
        output PENABLE, PREADY, PRDATA, PSLVERR,
        input  gnt, rsp_rdata, rsp_err, busy, owner,
        input  IN_ADDR, IN_DATA, IN_WRITE, IN_STRB, IN_PROT, Transfer
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for an APB master: latches the winner's
// request, holds Transfer until the bus completes or times out, then pulses gnt.
module apb_req_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STRB_WIDTH    = 4,
    parameter int TIMEOUT       = 16
) (
    input logic              PCLK,
    input logic              PRESET,
    apb_req_arbiter_if.master bus
);
    localparam int CNT_W = ($clog2(TIMEOUT) + 1 > 5) ? $clog2(TIMEOUT) + 1 : 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
        logic                     write;
        logic [STRB_WIDTH-1:0]    strb;
        logic [2:0]               prot;
    } req_t;

    logic [1:0]            state;
    req_t                  lat;
    req_t                  win_req;
    logic                  win;
    logic                  owner_q;   // also serves as owner_last for round-robin
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  cpl;
    logic                  tmo;

    // With both asking, the one that did not go last wins; otherwise the lone requester.
    always_comb begin
        win             = (bus.req == 2'b11) ? ~owner_q : bus.req[1];
        win_req.addr    = bus.req_addr[win];
        win_req.wdata   = bus.req_wdata[win];
        win_req.write   = bus.req_write[win];
        win_req.strb    = bus.req_strb[win];
        win_req.prot    = bus.req_prot[win];
    end

    assign cpl = bus.PENABLE & bus.PREADY;
    assign tmo = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            lat      <= '0;
            owner_q  <= 1'b1;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req) begin
                    lat      <= win_req;
                    owner_q  <= win;
                    wait_cnt <= '0;
                    state    <= BUSY;
                end
                BUSY: if (cpl) begin
                    // completion beats a same-cycle timeout
                    rdata_q <= bus.PRDATA;
                    err_q   <= bus.PSLVERR;
                    state   <= DONE;
                end else if (tmo) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    state   <= DONE;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Transfer  = (state == BUSY);
    assign bus.busy      = (state != IDLE);
    assign bus.gnt       = (state == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.owner     = owner_q;
    assign bus.IN_ADDR   = lat.addr;
    assign bus.IN_DATA   = lat.wdata;
    assign bus.IN_WRITE  = lat.write;
    assign bus.IN_STRB   = lat.strb;
    assign bus.IN_PROT   = lat.prot;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Random and directed stimulus for apb_req_arbiter, checked every cycle against a
// transaction-level model of requesters, round-robin ownership and bus completion.
module tb_apb_req_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    apb_req_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TMO)) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // requester-side stimulus state
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wdata[2];
    logic          r_write[2];
    logic [SW-1:0] r_strb[2];
    logic [2:0]    r_prot[2];
    bit            pend[2];
    bit            auto_req, hold_both, rdata_fix_en;
    logic [DW-1:0] rdata_fix;
    int            mode;       // 0 random bus, 1 ready on 2nd cycle, 2 never ready, 3 ready on cycle TMO
    int            force_err;  // -1 random PSLVERR
    int            xfer_seen;
    int            gnt_q[$];

    // reference model: transaction view
    int            m_xfer;     // index of current Transfer cycle, 0 when none
    bit            m_gnt;
    bit            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_write, m_err;
    logic [SW-1:0] m_strb;
    logic [2:0]    m_prot;

    task automatic model_reset();
        m_xfer = 0; m_gnt = 0; m_last = 1'b1;
        m_addr = '0; m_wdata = '0; m_write = 1'b0; m_strb = '0; m_prot = '0;
        m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic arm(input int i);
        pend[i]    = 1'b1;
        r_addr[i]  = AW'($urandom);
        r_wdata[i] = DW'($urandom);
        r_write[i] = 1'($urandom_range(0, 1));
        r_strb[i]  = SW'($urandom);
        r_prot[i]  = 3'($urandom);
    endtask

    task automatic drive_req();
        for (int i = 0; i < 2; i++) begin
            bus.req[i]       = pend[i];
            bus.req_addr[i]  = r_addr[i];
            bus.req_wdata[i] = r_wdata[i];
            bus.req_write[i] = r_write[i];
            bus.req_strb[i]  = r_strb[i];
            bus.req_prot[i]  = r_prot[i];
        end
    endtask

    task automatic check_outputs();
        chk("transfer", bus.Transfer, m_xfer > 0);
        chk("busy", bus.busy, (m_xfer > 0) || m_gnt);
        chk("gnt", bus.gnt, m_gnt ? (m_last ? 2 : 1) : 0);
        chk("owner", bus.owner, m_last);
        chk("in_addr", bus.IN_ADDR, m_addr);
        chk("in_data", bus.IN_DATA, m_wdata);
        chk("in_write", bus.IN_WRITE, m_write);
        chk("in_strb", bus.IN_STRB, m_strb);
        chk("in_prot", bus.IN_PROT, m_prot);
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", bus.rsp_err, m_err);
    endtask

    // Called at a negedge: drive inputs for the coming edge, predict, then check.
    task automatic step();
        bit rdy;
        if (m_gnt) begin
            pend[m_last] = 1'b0;
            if (hold_both) arm(int'(m_last));
        end
        if (auto_req) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0) arm(i);
            if (m_xfer > 0 && $urandom_range(0, 24) == 0) pend[m_last] = 1'b0;
        end
        drive_req();
        case (mode)
            1:       rdy = (m_xfer == 2);
            2:       rdy = 1'b0;
            3:       rdy = (m_xfer == TMO);
            default: rdy = ($urandom_range(0, 2) == 0);
        endcase
        bus.PENABLE = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.PREADY  = rdy;
        bus.PRDATA  = rdata_fix_en ? rdata_fix : DW'($urandom);
        bus.PSLVERR = (force_err < 0) ? 1'($urandom_range(0, 1)) : 1'(force_err);

        if (m_gnt) begin
            m_gnt = 0;
        end else if (m_xfer > 0) begin
            if (bus.PENABLE && bus.PREADY) begin
                m_rdata = bus.PRDATA; m_err = bus.PSLVERR; m_xfer = 0; m_gnt = 1;
            end else if (m_xfer == TMO) begin
                m_rdata = '0; m_err = 1'b1; m_xfer = 0; m_gnt = 1;
            end else begin
                m_xfer++;
            end
        end else if (pend[0] || pend[1]) begin
            m_last  = (pend[0] && pend[1]) ? !m_last : pend[1];
            m_addr  = r_addr[m_last];  m_wdata = r_wdata[m_last];
            m_write = r_write[m_last]; m_strb  = r_strb[m_last];
            m_prot  = r_prot[m_last];  m_xfer  = 1;
        end

        @(negedge PCLK);
        check_outputs();
        if (bus.Transfer) xfer_seen++;
        if (bus.gnt != 2'b00) gnt_q.push_back(int'(bus.gnt[1]));
    endtask

    task automatic run_xfer(output int ncyc);
        bit got = 0;
        xfer_seen = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            step();
            got = (bus.gnt != 2'b00);
        end
        if (!got) chk("gnt_budget", 0, 1);
        ncyc = xfer_seen;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        for (int i = 0; i < 2; i++) pend[i] = 1'b0;
        drive_req();
        model_reset();
        @(negedge PCLK);
        check_outputs();
        PRESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_write[i] = 1'b0;
            r_strb[i] = '0; r_prot[i] = '0; pend[i] = 1'b0;
        end
        auto_req = 0; hold_both = 0; rdata_fix_en = 0; rdata_fix = '0;
        mode = 0; force_err = -1; xfer_seen = 0;
        bus.PENABLE = 1'b0; bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
        drive_req();
        model_reset();
        repeat (2) @(negedge PCLK);
        check_outputs();
        PRESET = 1'b0;

        // single read, ready on the 2nd BUSY cycle
        mode = 1; force_err = 0; rdata_fix_en = 1; rdata_fix = 32'hA5A5_0001;
        arm(0); r_addr[0] = 32'h0000_0104; r_write[0] = 1'b0;
        run_xfer(n);
        chk("rd_len", n, 2);
        chk("rd_gnt", bus.gnt, 2'b01);
        chk("rd_addr", bus.IN_ADDR, 32'h104);
        chk("rd_data", bus.rsp_rdata, 32'hA5A5_0001);
        chk("rd_err", bus.rsp_err, 0);
        repeat (2) step();

        // slave error on a write
        force_err = 1; rdata_fix_en = 0;
        arm(1); r_write[1] = 1'b1;
        run_xfer(n);
        chk("slverr_gnt", bus.gnt, 2'b10);
        chk("slverr_err", bus.rsp_err, 1);
        step();

        // timeout
        mode = 2; force_err = 0;
        arm(0);
        run_xfer(n);
        chk("tmo_len", n, TMO);
        chk("tmo_err", bus.rsp_err, 1);
        chk("tmo_rdata", bus.rsp_rdata, 0);
        step();

        // completion on the timeout cycle wins
        mode = 3; force_err = 0; rdata_fix_en = 1; rdata_fix = 32'h1234_5678;
        arm(1);
        run_xfer(n);
        chk("edge_len", n, TMO);
        chk("edge_err", bus.rsp_err, 0);
        chk("edge_rdata", bus.rsp_rdata, 32'h1234_5678);
        step();
        rdata_fix_en = 0;

        // req dropped mid-BUSY still completes with gnt
        mode = 3;
        arm(0);
        xfer_seen = 0;
        for (int k = 0; k < 10 && xfer_seen < 2; k++) step();
        pend[0] = 1'b0;
        run_xfer(n);
        chk("drop_gnt", bus.gnt, 2'b01);
        step();

        // contention from reset: order 0,1,0,1
        do_reset();
        mode = 0; force_err = -1; hold_both = 1;
        arm(0); arm(1); r_write[0] = 1'b1; r_write[1] = 1'b1;
        gnt_q.delete();
        for (int k = 0; k < 4; k++) run_xfer(n);
        hold_both = 0;
        chk("order_cnt", gnt_q.size(), 4);
        for (int k = 0; k < 4 && k < gnt_q.size(); k++) chk("order", gnt_q[k], k & 1);
        run_xfer(n);
        step();

        // asynchronous reset on the 3rd BUSY cycle
        mode = 2;
        arm(0);
        xfer_seen = 0;
        for (int k = 0; k < 10 && xfer_seen < 3; k++) step();
        #1 PRESET = 1'b1;
        #1;
        chk("rst_xfer", bus.Transfer, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gnt", bus.gnt, 0);
        do_reset();
        mode = 0;
        arm(1);
        run_xfer(n);
        chk("post_rst_gnt", bus.gnt, 2'b10);
        step();

        // random traffic
        auto_req = 1; mode = 0; force_err = -1;
        repeat (3000) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
